// File: rtl/rf_bus_pkg.sv
// rf_bus_pkg: shared definitions for the rf_bus_if register-file front end.
// Holds the FSM state encoding, default widths and the strobe-width helper.
package rf_bus_pkg;

   localparam int ADDR_W_DEF = 3;
   localparam int DATA_W_DEF = 32;
   localparam int STRB_W_DEF = DATA_W_DEF / 8;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_WR     = 3'd1,
      ST_RD     = 3'd2,
      ST_RMW_RD = 3'd3,
      ST_RESP   = 3'd4
   } state_t;

   // One strobe bit per data byte.
   function automatic int strb_w(input int dw);
      return dw / 8;
   endfunction

endpackage

// File: rtl/rf_bus_if_if.sv
// rf_bus_intf: request/response bus plus register-file port bundle.
// slave  = the rf_bus_if block itself.
// master = the requester / register-file environment around it.
interface rf_bus_intf #(
   parameter int ADDR_W = 3,
   parameter int DATA_W = 32
) ();
   localparam int STRB_W = DATA_W / 8;

   // requester side
   logic              s_req;
   logic              s_wr;
   logic [ADDR_W-1:0] s_addr;
   logic [DATA_W-1:0] s_wdata;
   logic [STRB_W-1:0] s_strb;
   logic              s_ack;
   logic [DATA_W-1:0] s_rdata;
   logic              s_rvalid;
   logic              busy;

   // register-file side
   logic [ADDR_W-1:0] rf_wAddr;
   logic [DATA_W-1:0] rf_wData;
   logic              rf_we;
   logic [ADDR_W-1:0] rf_rAddr;
   logic [DATA_W-1:0] rf_rData;

   modport slave (
      input  s_req, s_wr, s_addr, s_wdata, s_strb, rf_rData,
      output s_ack, s_rdata, s_rvalid, busy,
             rf_wAddr, rf_wData, rf_we, rf_rAddr
   );

   modport master (
      output s_req, s_wr, s_addr, s_wdata, s_strb, rf_rData,
      input  s_ack, s_rdata, s_rvalid, busy,
             rf_wAddr, rf_wData, rf_we, rf_rAddr
   );
endinterface

// File: rtl/rf_bus_if_byte_merge.sv
// rf_byte_merge: combinational byte-lane merge for partial writes.
// Each byte with strobe=1 comes from the new word, otherwise from the old word.
module rf_byte_merge #(
   parameter int DATA_W = 32
) (
   input  logic [DATA_W-1:0]   i_old,
   input  logic [DATA_W-1:0]   i_new,
   input  logic [DATA_W/8-1:0] i_strb,
   output logic [DATA_W-1:0]   o_merged
);
   localparam int NB = DATA_W / 8;

   for (genvar b = 0; b < NB; b++) begin : g_lane
      assign o_merged[b*8 +: 8] = i_strb[b] ? i_new[b*8 +: 8] : i_old[b*8 +: 8];
   end
endmodule

// File: rtl/rf_bus_if.sv
// rf_bus_if: single-request bus front end for a combinational-read register file.
// Write: IDLE->WR (ack with rf_we). Read: IDLE->RD->RESP (rvalid+ack).
// Optional feature macro RF_BYTE_STRB_EN: partial-strobe writes go through
// RMW_RD to merge old bytes; an all-zero strobe acks without writing.
module rf_bus_if
   import rf_bus_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int DATA_W = DATA_W_DEF
) (
   input  logic      clk,
   input  logic      reset_n,
   rf_bus_intf.slave bus
);
   localparam int STRB_W = strb_w(DATA_W);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic [DATA_W-1:0] r_rdata;
   logic              w_we;
   logic              w_ack;
   logic              w_rvalid;
   logic [ADDR_W-1:0] w_raddr;

`ifdef RF_BYTE_STRB_EN
   logic [STRB_W-1:0] r_strb;
   logic              r_nowe;
   logic [DATA_W-1:0] w_merged;
   logic              w_strb_full;
   logic              w_strb_none;

   assign w_strb_full = (bus.s_strb == {STRB_W{1'b1}});
   assign w_strb_none = (bus.s_strb == '0);

   // Old word comes straight from the register file during RMW_RD.
   rf_byte_merge #(.DATA_W(DATA_W)) u_merge (
      .i_old    (bus.rf_rData),
      .i_new    (r_data),
      .i_strb   (r_strb),
      .o_merged (w_merged)
   );
`endif

   // State register; reset aborts any in-flight request.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Request capture in IDLE; partial writes fold old bytes in during RMW_RD.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_addr <= '0;
         r_data <= '0;
`ifdef RF_BYTE_STRB_EN
         r_strb <= '0;
         r_nowe <= 1'b0;
`endif
      end else if (r_state == ST_IDLE && bus.s_req) begin
         r_addr <= bus.s_addr;
         r_data <= bus.s_wdata;
`ifdef RF_BYTE_STRB_EN
         r_strb <= bus.s_strb;
         r_nowe <= w_strb_none;
`endif
      end
`ifdef RF_BYTE_STRB_EN
      else if (r_state == ST_RMW_RD) begin
         r_data <= w_merged;
      end
`endif
   end

   // Read data is captured in RD and held until the next read.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)               r_rdata <= '0;
      else if (r_state == ST_RD)  r_rdata <= bus.rf_rData;
   end

   // Next-state and Moore outputs.
   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_ack       = 1'b0;
      w_rvalid    = 1'b0;
      w_raddr     = '0;
      case (r_state)
         ST_IDLE: begin
            if (bus.s_req) begin
               if (bus.s_wr) begin
`ifdef RF_BYTE_STRB_EN
                  if (w_strb_full || w_strb_none) w_state_nxt = ST_WR;
                  else                            w_state_nxt = ST_RMW_RD;
`else
                  w_state_nxt = ST_WR;
`endif
               end else begin
                  w_state_nxt = ST_RD;
               end
            end
         end
         ST_WR: begin
`ifdef RF_BYTE_STRB_EN
            w_we = ~r_nowe;
`else
            w_we = 1'b1;
`endif
            w_ack       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         ST_RD: begin
            w_raddr     = r_addr;
            w_state_nxt = ST_RESP;
         end
         ST_RMW_RD: begin
            w_raddr     = r_addr;
`ifdef RF_BYTE_STRB_EN
            w_state_nxt = ST_WR;
`else
            w_state_nxt = ST_IDLE;
`endif
         end
         ST_RESP: begin
            w_rvalid    = 1'b1;
            w_ack       = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign bus.s_ack    = w_ack;
   assign bus.s_rvalid = w_rvalid;
   assign bus.s_rdata  = r_rdata;
   assign bus.busy     = (r_state != ST_IDLE);
   assign bus.rf_we    = w_we;
   assign bus.rf_wAddr = r_addr;
   assign bus.rf_wData = r_data;
   assign bus.rf_rAddr = w_raddr;

endmodule

// File: tb/tb_rf_bus_if.sv
// tb_rf_bus_if: randomized self-checking bench for rf_bus_if.
// Expected behaviour comes from a transaction-level memory model
// (latency/pulse counts per request type, byte merge per strobe).
module tb_rf_bus_if;
   localparam int AW = 3;
   localparam int DW = 32;
   localparam int SW = DW / 8;
   localparam int NE = 1 << AW;
`ifdef RF_BYTE_STRB_EN
   localparam bit STRB_EN = 1'b1;
`else
   localparam bit STRB_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   rf_bus_intf #(.ADDR_W(AW), .DATA_W(DW)) bus ();
   rf_bus_if #(.ADDR_W(AW), .DATA_W(DW)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   // Register file attached to the DUT (reset value 0, combinational read).
   logic [DW-1:0] rf_mem [0:NE-1];
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) for (int i = 0; i < NE; i++) rf_mem[i] <= '0;
      else if (bus.rf_we) rf_mem[bus.rf_wAddr] <= bus.rf_wData;
   end
   assign bus.rf_rData = rf_mem[bus.rf_rAddr];

   // Reference memory contents expected after each completed request.
   logic [DW-1:0] ref_mem [0:NE-1];
   int n_chk = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h exp %0h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] merge_ref(input logic [DW-1:0] o, input logic [DW-1:0] n,
                                               input logic [SW-1:0] s);
      logic [DW-1:0] r;
      for (int b = 0; b < SW; b++) r[b*8 +: 8] = s[b] ? n[b*8 +: 8] : o[b*8 +: 8];
      return r;
   endfunction

   task automatic step();
      @(posedge clk); #1;
   endtask

   // One request, checked against the model; returns in IDLE at posedge+1.
   task automatic txn(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [SW-1:0] st);
      logic [SW-1:0] eff;
      logic [DW-1:0] exp_word, rd, wd;
      logic [AW-1:0] wa;
      int exp_ack, exp_we, ack_cyc, we_cnt, rv_cyc, rv_cnt;
      logic busy_at_ack;
      eff = STRB_EN ? st : {SW{1'b1}};
      ack_cyc = 0; we_cnt = 0; rv_cyc = 0; rv_cnt = 0;
      rd = '0; wd = '0; wa = '0; busy_at_ack = 1'b0;
      if (wr) begin
         exp_word = merge_ref(ref_mem[a], d, eff);
         exp_we   = (eff != '0) ? 1 : 0;
         exp_ack  = (eff != '0 && eff != {SW{1'b1}}) ? 2 : 1;
      end else begin
         exp_word = ref_mem[a];
         exp_we   = 0;
         exp_ack  = 2;
      end
      bus.s_req = 1'b1; bus.s_wr = wr; bus.s_addr = a; bus.s_wdata = d; bus.s_strb = st;
      step();
      bus.s_req = 1'b0;
      for (int k = 1; k <= 6; k++) begin
         if (bus.rf_we) begin we_cnt++; wa = bus.rf_wAddr; wd = bus.rf_wData; end
         if (bus.s_rvalid) begin rv_cnt++; rv_cyc = k; rd = bus.s_rdata; end
         if (bus.s_ack) begin ack_cyc = k; busy_at_ack = bus.busy; break; end
         step();
      end
      check(wr ? "wr_ack_lat" : "rd_ack_lat", ack_cyc, exp_ack);
      check("busy_at_ack", busy_at_ack, 1);
      check("we_count", we_cnt, exp_we);
      if (exp_we != 0) begin
         check("we_addr", wa, a);
         check("we_data", wd, exp_word);
      end
      if (!wr) begin
         check("rvalid_lat", rv_cyc, 2);
         check("rvalid_cnt", rv_cnt, 1);
         check("rdata", rd, exp_word);
      end
      step();
      check("busy_after", bus.busy, 0);
      check("we_after", bus.rf_we, 0);
      check("ack_after", bus.s_ack, 0);
      if (!wr) check("rdata_hold", bus.s_rdata, exp_word);
      if (wr) ref_mem[a] = exp_word;
   endtask

   initial begin
      logic [DW-1:0] dd, rdv, wdv;
      int we_cnt, we_cyc, rv_cyc;
      logic busy3;
      bus.s_req = 1'b0; bus.s_wr = 1'b0; bus.s_addr = '0; bus.s_wdata = '0; bus.s_strb = '0;
      for (int i = 0; i < NE; i++) ref_mem[i] = '0;

      // Reset state.
      #12;
      check("rst_busy", bus.busy, 0);
      check("rst_ack", bus.s_ack, 0);
      check("rst_rvalid", bus.s_rvalid, 0);
      check("rst_we", bus.rf_we, 0);
      check("rst_rdata", bus.s_rdata, 0);
      check("rst_waddr", bus.rf_wAddr, 0);
      check("rst_wdata", bus.rf_wData, 0);
      check("rst_raddr", bus.rf_rAddr, 0);
      @(negedge clk); reset_n = 1'b1;

      // First write right at the first edge out of reset.
      txn(1'b1, 3'd0, 32'h1111_1111, 4'hF);

      // Writes then reads back.
      txn(1'b1, 3'd1, 32'h1ff1_ff11, 4'hF);
      txn(1'b1, 3'd5, 32'h1000_f011, 4'hF);
      txn(1'b1, 3'd7, 32'hefef_0101, 4'hF);
      txn(1'b0, 3'd1, 32'h0, 4'hF);
      txn(1'b0, 3'd5, 32'h0, 4'hF);
      txn(1'b0, 3'd7, 32'h0, 4'hF);
      txn(1'b0, 3'd0, 32'h0, 4'hF);

      // s_req held high: read of 3, then write to 3 once back in IDLE.
      dd = 32'hCAFE_0033;
      rdv = ref_mem[3];
      we_cnt = 0; we_cyc = 0; rv_cyc = 0; busy3 = 1'b1; wdv = '0;
      bus.s_req = 1'b1; bus.s_wr = 1'b0; bus.s_addr = 3'd3; bus.s_wdata = 32'h0; bus.s_strb = 4'hF;
      step();
      bus.s_wr = 1'b1; bus.s_wdata = dd;
      for (int k = 1; k <= 6; k++) begin
         if (bus.rf_we) begin we_cnt++; if (we_cyc == 0) we_cyc = k; wdv = bus.rf_wData; end
         if (bus.s_rvalid) begin rv_cyc = k; check("held_rdata", bus.s_rdata, rdv); end
         if (k == 3) busy3 = bus.busy;
         if (k == 4) bus.s_req = 1'b0;
         step();
      end
      check("held_rv_lat", rv_cyc, 2);
      check("held_idle_gap", busy3, 0);
      check("held_we_cnt", we_cnt, 1);
      check("held_we_cyc", we_cyc, 4);
      check("held_we_data", wdv, dd);
      ref_mem[3] = dd;
      txn(1'b0, 3'd3, 32'h0, 4'hF);

`ifdef RF_BYTE_STRB_EN
      // Partial-strobe read-modify-write, then an all-zero strobe.
      txn(1'b1, 3'd7, 32'h0000_AB00, 4'b0010);
      check("rmw_word", rf_mem[7], 32'hefef_AB01);
      txn(1'b0, 3'd7, 32'h0, 4'hF);
      txn(1'b1, 3'd7, 32'h5555_5555, 4'b0000);
      check("nostrb_word", rf_mem[7], 32'hefef_AB01);
`endif

      // Reset in the middle of WR aborts the write.
      bus.s_req = 1'b1; bus.s_wr = 1'b1; bus.s_addr = 3'd6; bus.s_wdata = 32'h6666_abcd; bus.s_strb = 4'hF;
      step();
      bus.s_req = 1'b0;
      check("mid_we_before", bus.rf_we, 1);
      #2 reset_n = 1'b0;
      #1;
      check("mid_we_drop", bus.rf_we, 0);
      check("mid_busy_drop", bus.busy, 0);
      check("mid_ack_drop", bus.s_ack, 0);
      for (int i = 0; i < NE; i++) ref_mem[i] = '0;
      @(negedge clk); reset_n = 1'b1;
      txn(1'b0, 3'd6, 32'h0, 4'hF);

      // Randomized traffic.
      for (int n = 0; n < 60; n++) begin
         logic [SW-1:0] st;
         int sel;
         sel = $urandom_range(0, 3);
         if (sel == 0)      st = '0;
         else if (sel == 1) st = '1;
         else               st = SW'($urandom);
         txn(1'($urandom_range(0, 1)), AW'($urandom), DW'($urandom), st);
         repeat ($urandom_range(0, 2)) step();
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
